uart_msg_seq: RTL

Parametrised message sequencer for the byte-level UART transmitter. Streams a compile-time message of MSG_LEN bytes through the transmitter's start/done handshake. Supports single-shot, periodic repeat with a programmable inter-message gap, and a one-byte echo path for received bytes. Sits between board-level control and the UART top, and replaces hard-coded per-message sequencers.

---
 rtl/uart_msg_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_msg_seq.sv
// uart_msg_seq: streams a compile-time message of MSG_LEN bytes to a byte-level UART
// transmitter over its start/done handshake. It supports single-shot sends, periodic
// repeat with a programmable inter-message gap, and a one-byte echo slot for received
// bytes. An echo byte is only served between messages, never inside one.
//
// Ports:
//   clk        - single clock
//   reset      - asynchronous, active-high
//   send       - request one message (sampled only while idle)
//   repeat_en  - level, continuous repeat mode
//   echo_en    - level, enables capture of received bytes
//   rx_valid   - one-cycle pulse, rx_data is valid
//   rx_data    - received byte
//   tx_start   - one-cycle start pulse to the transmitter
//   tx_data    - byte to send, held until the next tx_start
//   tx_done    - one-cycle pulse, transmitter finished the byte
//   busy       - high whenever the sequencer is not idle
//   msg_done   - one-cycle pulse after the last message byte completes
//   echo_drop  - one-cycle pulse when a received byte is lost (slot occupied)
module uart_msg_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MSG_LEN = 5,
    parameter logic [MSG_LEN*DATA_WIDTH-1:0] MSG = 40'h48454C4C4F,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send,
    input  logic                  repeat_en,
    input  logic                  echo_en,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  msg_done,
    output logic                  echo_drop
);

    localparam int unsigned IdxW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(MSG_LEN - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StGap,
        StEchoLoad,
        StEchoWait
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic                  echo_full_q, echo_full_d;
    logic [DATA_WIDTH-1:0] echo_byte_q, echo_byte_d;

    logic                  tx_start_d;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic                  busy_d;
    logic                  msg_done_d;
    logic                  echo_drop_d;

    logic                  slot_free;
    logic                  capture;
    logic                  echo_pending;
    logic [DATA_WIDTH-1:0] echo_next_byte;

    // The slot empties during ECHO_LOAD, so a byte arriving that cycle is accepted.
    assign slot_free = !echo_full_q || (state_q == StEchoLoad);
    assign capture   = rx_valid && echo_en && slot_free;

    // A byte captured this very cycle already counts as pending, which lets an echo win
    // over a send request arriving in the same idle cycle.
    assign echo_pending   = echo_full_q || capture;
    assign echo_next_byte = capture ? rx_data : echo_byte_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        echo_full_d = echo_full_q;
        echo_byte_d = echo_byte_q;
        msg_done_d  = 1'b0;
        echo_drop_d = rx_valid && echo_en && !slot_free;

        if (state_q == StEchoLoad) begin
            echo_full_d = 1'b0;
        end
        if (capture) begin
            echo_full_d = 1'b1;
            echo_byte_d = rx_data;
        end

        unique case (state_q)
            StIdle: begin
                if (echo_pending) begin
                    state_d = StEchoLoad;
                end else if (send || repeat_en) begin
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StWait;
            StWait: begin
                if (tx_done) begin
                    if (idx_q == LastIdx) begin
                        msg_done_d = 1'b1;
                        if (repeat_en) begin
                            gap_d   = '0;
                            state_d = StGap;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            StGap: begin
                if (!repeat_en) begin
                    state_d = StIdle;
                end else if (echo_pending) begin
                    state_d = StEchoLoad;
                end else if (gap_q == GapLast) begin
                    idx_d   = '0;
                    state_d = StLoad;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StEchoLoad: state_d = StEchoWait;
            StEchoWait: begin
                if (tx_done) begin
                    if (repeat_en) begin
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the next state.
        tx_start_d = (state_d == StLoad) || (state_d == StEchoLoad);
        busy_d     = (state_d != StIdle);
        tx_data_d  = tx_data;
        if (state_d == StLoad) begin
            tx_data_d = MSG[(MSG_LEN - 1 - int'(idx_d)) * DATA_WIDTH +: DATA_WIDTH];
        end else if (state_d == StEchoLoad) begin
            tx_data_d = echo_next_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            gap_q       <= '0;
            echo_full_q <= 1'b0;
            echo_byte_q <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            msg_done    <= 1'b0;
            echo_drop   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            echo_full_q <= echo_full_d;
            echo_byte_q <= echo_byte_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            busy        <= busy_d;
            msg_done    <= msg_done_d;
            echo_drop   <= echo_drop_d;
        end
    end

endmodule
